// File: rtl/quad_enc_pkg.sv
// quad_enc_pkg: shared mode/AB types and Gray-code sequence for quad_enc_counter; QE_FILTER_EN enables the input filter.
package quad_enc_pkg;

    typedef enum logic [1:0] {
        QE_X4 = 2'b00,
        QE_X2 = 2'b01,
        QE_X1 = 2'b10
    } qe_mode_t;

    typedef logic [1:0] qe_ab_t;

    localparam qe_ab_t QE_AB_S0 = 2'b00;
    localparam qe_ab_t QE_AB_S1 = 2'b10;
    localparam qe_ab_t QE_AB_S2 = 2'b11;
    localparam qe_ab_t QE_AB_S3 = 2'b01;

`ifdef QE_FILTER_EN
    localparam bit QE_FILT_EN = 1'b1;
`else
    localparam bit QE_FILT_EN = 1'b0;
`endif

    // AB is packed {A, B}; forward rotation walks S0 -> S1 -> S2 -> S3 -> S0
    function automatic qe_ab_t qe_fwd_next(input qe_ab_t ab);
        return (ab == QE_AB_S0) ? QE_AB_S1 :
               (ab == QE_AB_S1) ? QE_AB_S2 :
               (ab == QE_AB_S2) ? QE_AB_S3 : QE_AB_S0;
    endfunction

endpackage

// File: rtl/quad_enc_input_sync.sv
// quad_enc_input_sync: SYNC_STAGES-deep synchroniser with an optional FILT_LEN stability filter (QE_FILTER_EN).
module quad_enc_input_sync
    import quad_enc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef QE_FILTER_EN
   ,parameter int FILT_LEN = 4
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], din};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= sync_d;
    end

`ifdef QE_FILTER_EN
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;
    logic          raw;

    assign raw = sync_q[SYNC_STAGES-1];

    // the filtered value follows only after FILT_LEN consecutive differing samples
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (raw != filt_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) filt_d = raw;
            else                            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign dout = filt_q;
`else
    assign dout = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_enc_counter.sv
// quad_enc_counter: x1/x2/x4 quadrature decoder with wrapping position, preset, index capture/clear and sticky error; QE_FILTER_EN adds input filtering.
module quad_enc_counter
    import quad_enc_pkg::*;
#(
    parameter int POS_WIDTH   = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 quadA_in,
    input  logic                 quadB_in,
    input  logic                 quadI_in,
    input  logic [1:0]           mode,
    input  logic                 index_clear_en,
    input  logic                 preset_load,
    input  logic [POS_WIDTH-1:0] preset_value,
    input  logic                 error_clear,
    output logic                 count_pulse,
    output logic                 direction,
    output logic [POS_WIDTH-1:0] position,
    output logic [POS_WIDTH-1:0] index_pos,
    output logic                 index_seen,
    output logic                 quad_error
);

    localparam int PRIME_LEN = SYNC_STAGES + 1 + (QE_FILT_EN ? FILT_LEN : 0);
    localparam int PW        = $clog2(PRIME_LEN + 1);

    logic [2:0] pins, synced;

    assign pins = {quadA_in, quadB_in, quadI_in};

    for (genvar i = 0; i < 3; i++) begin : g_sync
        quad_enc_input_sync #(
            .SYNC_STAGES(SYNC_STAGES)
`ifdef QE_FILTER_EN
           ,.FILT_LEN(FILT_LEN)
`endif
        ) u_sync (
            .clk  (clk),
            .reset(reset),
            .din  (pins[i]),
            .dout (synced[i])
        );
    end

    logic [PW-1:0]        prime_q, prime_d;
    qe_ab_t               ab_q, ab_d, ab_prev_q, ab_prev_d;
    logic                 i_q, i_d, i_prev_q, i_prev_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d, index_pos_q, index_pos_d;
    logic                 count_pulse_q, count_pulse_d;
    logic                 direction_q, direction_d;
    logic                 index_seen_q, index_seen_d;
    logic                 quad_error_q, quad_error_d;

    logic                 priming, fwd, rev, illegal, step, idx_edge;
    logic [POS_WIDTH-1:0] pos_step;

    // while priming, both history registers track the synchronised inputs so release never looks like a step
    always_comb begin
        priming     = prime_q < PW'(PRIME_LEN);
        prime_d     = priming ? prime_q + 1'b1 : prime_q;
        ab_d        = synced[2:1];
        i_d         = synced[0];
        ab_prev_d   = priming ? synced[2:1] : ab_q;
        i_prev_d    = priming ? synced[0] : i_q;
        fwd         = !priming && (ab_q == qe_fwd_next(ab_prev_q));
        rev         = !priming && (ab_prev_q == qe_fwd_next(ab_q));
        illegal     = !priming && ((ab_q ^ ab_prev_q) == 2'b11);
        step        = (mode == QE_X2) ? (fwd || rev) && (ab_q[1] != ab_prev_q[1]) :
                      (mode == QE_X1) ? (fwd && ab_prev_q == QE_AB_S0) || (rev && ab_prev_q == QE_AB_S1) :
                                        (fwd || rev);
        idx_edge    = !priming && i_q && !i_prev_q;
        pos_step    = step ? (fwd ? pos_q + 1'b1 : pos_q - 1'b1) : pos_q;
        pos_d       = preset_load ? preset_value : (idx_edge && index_clear_en) ? '0 : pos_step;
        index_pos_d = idx_edge ? pos_step : index_pos_q;
        count_pulse_d = step;
        direction_d   = step ? fwd : direction_q;
        index_seen_d  = idx_edge || (index_seen_q && !error_clear);
        quad_error_d  = illegal || (quad_error_q && !error_clear);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prime_q       <= '0;
            ab_q          <= '0;
            ab_prev_q     <= '0;
            i_q           <= 1'b0;
            i_prev_q      <= 1'b0;
            pos_q         <= '0;
            index_pos_q   <= '0;
            count_pulse_q <= 1'b0;
            direction_q   <= 1'b0;
            index_seen_q  <= 1'b0;
            quad_error_q  <= 1'b0;
        end else begin
            prime_q       <= prime_d;
            ab_q          <= ab_d;
            ab_prev_q     <= ab_prev_d;
            i_q           <= i_d;
            i_prev_q      <= i_prev_d;
            pos_q         <= pos_d;
            index_pos_q   <= index_pos_d;
            count_pulse_q <= count_pulse_d;
            direction_q   <= direction_d;
            index_seen_q  <= index_seen_d;
            quad_error_q  <= quad_error_d;
        end
    end

    assign count_pulse = count_pulse_q;
    assign direction   = direction_q;
    assign position    = pos_q;
    assign index_pos   = index_pos_q;
    assign index_seen  = index_seen_q;
    assign quad_error  = quad_error_q;

endmodule

// File: tb/tb_quad_enc_counter.sv
// tb_quad_enc_counter: vector table for rotation counts per mode plus directed wrap, error, index, priority and reset sequences.
module tb_quad_enc_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        qa = 1'b0, qb = 1'b0, qi = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        index_clear_en = 1'b0;
    logic        preset_load = 1'b0;
    logic [31:0] preset_value = '0;
    logic        error_clear = 1'b0;
    logic        count_pulse, direction, index_seen, quad_error;
    logic [31:0] position, index_pos;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int p0;

    quad_enc_counter dut (
        .clk           (clk),
        .reset         (reset),
        .quadA_in      (qa),
        .quadB_in      (qb),
        .quadI_in      (qi),
        .mode          (mode),
        .index_clear_en(index_clear_en),
        .preset_load   (preset_load),
        .preset_value  (preset_value),
        .error_clear   (error_clear),
        .count_pulse   (count_pulse),
        .direction     (direction),
        .position      (position),
        .index_pos     (index_pos),
        .index_seen    (index_seen),
        .quad_error    (quad_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (count_pulse === 1'b1) pulses <= pulses + 1;

    typedef struct {
        logic [1:0]  mode;
        int          cycles;
        bit          fwd;
        logic [31:0] start;
        logic [31:0] exp_pos;
        int          exp_pulses;
        logic        exp_dir;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ab(input logic [1:0] ab);
        {qa, qb} = ab;
        tick(8);
    endtask

    task automatic rot(input bit fwd);
        if (fwd) begin
            set_ab(2'b10); set_ab(2'b11); set_ab(2'b01); set_ab(2'b00);
        end else begin
            set_ab(2'b01); set_ab(2'b11); set_ab(2'b10); set_ab(2'b00);
        end
    endtask

    task automatic preset(input logic [31:0] v);
        preset_value = v;
        preset_load  = 1'b1;
        tick(1);
        preset_load  = 1'b0;
        tick(1);
    endtask

    task automatic pulse_clear();
        error_clear = 1'b1;
        tick(1);
        error_clear = 1'b0;
        tick(1);
    endtask

    initial begin
        vecs[0] = '{2'b00, 10, 1'b1, 32'd0,   32'd40, 40, 1'b1};
        vecs[1] = '{2'b00, 10, 1'b0, 32'd40,  32'd0,  40, 1'b0};
        vecs[2] = '{2'b10, 10, 1'b1, 32'd0,   32'd10, 10, 1'b1};
        vecs[3] = '{2'b01, 10, 1'b1, 32'd0,   32'd20, 20, 1'b1};
        vecs[4] = '{2'b10, 10, 1'b0, 32'd10,  32'd0,  10, 1'b0};
        vecs[5] = '{2'b11, 2,  1'b1, 32'd0,   32'd8,  8,  1'b1};
        vecs[6] = '{2'b01, 3,  1'b0, 32'd100, 32'd94, 6,  1'b0};

        tick(1);
        chk("rst_position", position, 32'd0);
        chk("rst_index_pos", index_pos, 32'd0);
        chk("rst_count_pulse", {31'd0, count_pulse}, 32'd0);
        chk("rst_direction", {31'd0, direction}, 32'd0);
        chk("rst_index_seen", {31'd0, index_seen}, 32'd0);
        chk("rst_quad_error", {31'd0, quad_error}, 32'd0);
        reset = 1'b0;
        tick(6);

        for (int i = 0; i < 7; i++) begin
            mode = vecs[i].mode;
            if (i > 0) preset(vecs[i].start);
            p0 = pulses;
            repeat (vecs[i].cycles) rot(vecs[i].fwd);
            tick(2);
            chk($sformatf("vec%0d_position", i), position, vecs[i].exp_pos);
            chk($sformatf("vec%0d_pulses", i), 32'(pulses - p0), 32'(vecs[i].exp_pulses));
            chk($sformatf("vec%0d_direction", i), {31'd0, direction}, {31'd0, vecs[i].exp_dir});
        end

        mode = 2'b00;
        preset(32'd0);
        set_ab(2'b01);
        chk("wrap_down_position", position, 32'hFFFF_FFFF);
        chk("wrap_down_direction", {31'd0, direction}, 32'd0);
        set_ab(2'b00);
        chk("wrap_up_position", position, 32'd0);
        chk("wrap_up_direction", {31'd0, direction}, 32'd1);

        p0 = pulses;
        set_ab(2'b11);
        chk("illegal_quad_error", {31'd0, quad_error}, 32'd1);
        chk("illegal_position", position, 32'd0);
        chk("illegal_pulses", 32'(pulses - p0), 32'd0);
        chk("illegal_direction_held", {31'd0, direction}, 32'd1);
        set_ab(2'b00);
        pulse_clear();
        chk("error_cleared", {31'd0, quad_error}, 32'd0);

        preset(32'd123);
        qi = 1'b1;
        tick(8);
        chk("index_seen", {31'd0, index_seen}, 32'd1);
        chk("index_pos_123", index_pos, 32'd123);
        chk("index_noclear_position", position, 32'd123);
        set_ab(2'b10);
        chk("wide_index_position", position, 32'd124);
        chk("wide_index_single_capture", index_pos, 32'd123);
        qi = 1'b0;
        set_ab(2'b00);
        pulse_clear();
        chk("index_seen_cleared", {31'd0, index_seen}, 32'd0);

        index_clear_en = 1'b1;
        p0 = pulses;
        {qa, qb} = 2'b10;
        qi = 1'b1;
        tick(8);
        chk("index_clear_position", position, 32'd0);
        chk("index_clear_index_pos", index_pos, 32'd124);
        chk("index_clear_pulses", 32'(pulses - p0), 32'd1);
        chk("index_clear_seen", {31'd0, index_seen}, 32'd1);
        qi = 1'b0;
        tick(8);

        p0 = pulses;
        {qa, qb} = 2'b11;
        qi = 1'b1;
        tick(3);
        preset_value = 32'h55;
        preset_load  = 1'b1;
        tick(1);
        preset_load  = 1'b0;
        tick(4);
        chk("preset_priority_position", position, 32'h55);
        chk("preset_priority_pulses", 32'(pulses - p0), 32'd1);
        chk("preset_priority_direction", {31'd0, direction}, 32'd1);
        index_clear_en = 1'b0;
        qi = 1'b0;
        tick(8);

        {qa, qb} = 2'b01;
        tick(3);
        {qa, qb} = 2'b11;
        qi = 1'b1;
        #3 reset = 1'b1;
        tick(1);
        chk("midrst_position", position, 32'd0);
        chk("midrst_direction", {31'd0, direction}, 32'd0);
        chk("midrst_count_pulse", {31'd0, count_pulse}, 32'd0);
        tick(2);
        reset = 1'b0;
        p0 = pulses;
        tick(10);
        chk("prime_pulses", 32'(pulses - p0), 32'd0);
        chk("prime_position", position, 32'd0);
        chk("prime_quad_error", {31'd0, quad_error}, 32'd0);
        chk("prime_index_seen", {31'd0, index_seen}, 32'd0);
        chk("prime_index_pos", index_pos, 32'd0);
        chk("prime_direction", {31'd0, direction}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quad_enc_counter.md
Name: quad_enc_counter

Overview:
- Parametrised successor to the 4x quadrature decoder.
- Synchronises A/B/I encoder inputs and decodes Gray-code steps in selectable x1/x2/x4 resolution.
- Maintains a wrapping signed-agnostic position counter with preset, index capture/clear, and sticky illegal-transition detection.
- Sits between encoder pins and the motion-control register bank, one instance per motor channel.

Parameters:
- POS_WIDTH, 32: width of position, index_pos and preset_value.
- SYNC_STAGES, 2: synchroniser flops per input, minimum 2.
- FILT_LEN, 4: stable-sample count for the input filter; used only with QE_FILTER_EN.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- quadA_in  input  1  encoder channel A, asynchronous.
- quadB_in  input  1  encoder channel B, asynchronous.
- quadI_in  input  1  encoder index, asynchronous.
- mode  input  2  00=x4, 01=x2, 10=x1, 11=x4.
- index_clear_en  input  1  when 1, an index rising edge zeroes position.
- preset_load  input  1  single-cycle strobe: load preset_value into position.
- preset_value  input  POS_WIDTH  value loaded on preset_load.
- error_clear  input  1  single-cycle strobe: clears quad_error and index_seen.
- count_pulse  output  1  registered; 1 for one cycle per counted step.
- direction  output  1  registered; 1=up (A leads B), held between steps.
- position  output  POS_WIDTH  current count.
- index_pos  output  POS_WIDTH  position captured at last index rising edge.
- index_seen  output  1  sticky; set on index rising edge.
- quad_error  output  1  sticky; set on an illegal AB transition.

Behaviour:
- Reset, async on posedge reset: all sync and filter flops, outputs, position, index_pos and flags go to 0; direction=0.
- Priming: the decoder ignores AB transitions and index edges until SYNC_STAGES+1 clocks after reset deassertion. This prevents a spurious step when inputs are non-zero at release.
- Decode: compare previous synced AB with current AB each clock.
  - Forward sequence: 00→10→11→01→00. Reverse is the opposite sequence.
  - No change: no action.
- Illegal transition (both bits change):
  - No count; direction holds.
  - quad_error set next edge.
- Step qualification by mode:
  - x4: every legal step.
  - x2: only steps where A changes.
  - x1: only 00→10 (up) and 10→00 (down).
- Counted step:
  - Next edge: count_pulse=1 for 1 cycle; direction updated; position ±1.
  - Position wraps modulo 2^POS_WIDTH (0−1 → all-ones; all-ones+1 → 0).
- Latency, filter off: a pin edge sampled at edge N gives count_pulse and updated position after edge N+SYNC_STAGES+1.
- Index:
  - Rising edge of synced I: index_seen set.
  - index_pos captures the position value that would result this cycle, including any same-cycle count.
  - If index_clear_en=1, position becomes 0 instead.
  - A pulse wider than one clock produces one capture only.
- Position priority in a cycle: preset_load > index clear > count step.
  - count_pulse and direction still reflect the step even when overridden.
- error_clear: clears quad_error and index_seen. A same-cycle new error or index edge wins (flag stays 1).
- mode change takes effect on the next decoded step; no pipeline flush.

Optional Feature:
- Macro QE_FILTER_EN.
- Defined:
  - Each synced input passes through a FILT_LEN-sample stability filter.
  - The filtered output changes only after the input holds a new value for FILT_LEN consecutive clocks.
  - Latency increases by FILT_LEN clocks.
  - The priming window extends to SYNC_STAGES+FILT_LEN+1 clocks.
- Undefined: filter is a direct wire; FILT_LEN is ignored.

Decomposition:
- Package quad_enc_pkg:
  - typedef qe_mode_t enum (QE_X4, QE_X2, QE_X1).
  - typedef qe_ab_t, a 2-bit AB state.
  - Constants for the forward-sequence encodings.
- Sub-module quad_enc_input_sync, instantiated ×3 (A, B, I):
  - SYNC_STAGES synchroniser.
  - Optional QE_FILTER_EN filter.

Test Plan:
- x4, 10 forward cycles (40 legal steps, 8 clocks per state) from reset → position=40, 40 count_pulse cycles, direction=1. Then 10 reverse cycles → position=0, direction=0.
- mode=x1, 10 forward cycles → position=10. mode=x2, same stimulus → position=20.
- From position=0, one reverse step → position=2^POS_WIDTH−1. Then one forward step → 0.
- AB 00→11 in one clock → quad_error=1, position unchanged, no count_pulse. error_clear → quad_error=0.
- Index rising at position=123, index_clear_en=0 → index_pos=123, index_seen=1. Repeat with index_clear_en=1 and a same-cycle forward step → position=0, index_pos=124.
- preset_load=1, preset_value=0x55, same cycle as index clear and a count step → position=0x55. Reset asserted mid-rotation with inputs=11 at release → no count_pulse during priming, all outputs 0.
